// File: rtl/round_perm_iter_unit.sv
// rtl/round_perm_iter_unit.sv - iterated per-lane rotate permutation with valid/ready handshake
module round_perm_iter_unit #(
   parameter int                       LANES   = 4,
   parameter int                       LANE_W  = 16,
   parameter int                       SHIFT_W = 4,
   parameter logic [LANES*SHIFT_W-1:0] SHIFTS  = 16'h9741,
   parameter int                       CNT_W   = 4
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      in_valid,
   output logic                      in_ready,
   input  logic [LANES*LANE_W-1:0]   in_data,
   input  logic                      in_dec,
   input  logic [CNT_W-1:0]          in_iter,
   output logic                      out_valid,
   input  logic                      out_ready,
   output logic [LANES*LANE_W-1:0]   out_data,
   output logic                      out_dec,
   output logic                      busy
);

   localparam int W = LANES * LANE_W;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t             state;
   state_t             state_nx;
   logic [W-1:0]       data_reg;
   logic [W-1:0]       perm_data;
   logic               mode_reg;
   logic [CNT_W-1:0]   cnt;
   logic               accept;

   // One application of the permutation on the held word; lanes never exchange bits.
   // Amounts are folded modulo LANE_W at elaboration so 0 (or LANE_W) is the identity.
   for (genvar i = 0; i < LANES; i++) begin : g_lane
      localparam int AMT = int'(SHIFTS[i*SHIFT_W +: SHIFT_W]) % LANE_W;
      localparam int INV = (LANE_W - AMT) % LANE_W;
      logic [LANE_W-1:0] lane;
      logic [LANE_W-1:0] rol;
      logic [LANE_W-1:0] ror;
      assign lane = data_reg[i*LANE_W +: LANE_W];
      assign rol  = (lane << AMT) | (lane >> INV);
      assign ror  = (lane >> AMT) | (lane << INV);
      assign perm_data[i*LANE_W +: LANE_W] = mode_reg ? ror : rol;
   end

   // State register plus datapath: capture on accept, permute once per RUN cycle.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state    <= S_IDLE;
         data_reg <= '0;
         mode_reg <= 1'b0;
         cnt      <= '0;
      end else begin
         state <= state_nx;
         if (accept) begin
            data_reg <= in_data;
            mode_reg <= in_dec;
            cnt      <= in_iter;
         end else if (state == S_RUN) begin
            data_reg <= perm_data;
            cnt      <= cnt - 1'b1;
         end
      end
   end

   // Next-state and handshake decode; in_ready and busy depend on state alone.
   always_comb begin
      state_nx  = state;
      in_ready  = 1'b0;
      out_valid = 1'b0;
      busy      = 1'b0;
      accept    = 1'b0;
      case (state)
         S_IDLE: begin
            in_ready = 1'b1;
            if (in_valid) begin
               accept   = 1'b1;
               state_nx = (in_iter == '0) ? S_DONE : S_RUN;
            end
         end
         S_RUN: begin
            busy = 1'b1;
            if (cnt == CNT_W'(1)) state_nx = S_DONE;
         end
         S_DONE: begin
            busy      = 1'b1;
            out_valid = 1'b1;
            if (out_ready) state_nx = S_IDLE;
         end
         default: state_nx = S_IDLE;
      endcase
   end

   assign out_data = data_reg;
   assign out_dec  = mode_reg;

endmodule

// File: tb/tb_round_perm_iter_unit.sv
// tb/tb_round_perm_iter_unit.sv - directed self-checking bench for round_perm_iter_unit
module tb_round_perm_iter_unit;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        in_valid, in_ready, in_dec, out_valid, out_ready, out_dec, busy;
   logic [63:0] in_data, out_data;
   logic [3:0]  in_iter;

   logic        s_in_valid, s_in_ready, s_in_dec, s_out_valid, s_out_ready, s_out_dec, s_busy;
   logic [63:0] s_in_data, s_out_data;
   logic [3:0]  s_in_iter;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   round_perm_iter_unit dut (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_dec(in_dec), .in_iter(in_iter),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_dec(out_dec), .busy(busy)
   );

   round_perm_iter_unit #(
      .LANES(8), .LANE_W(8), .SHIFT_W(3),
      .SHIFTS({3'd7, 3'd6, 3'd5, 3'd4, 3'd3, 3'd2, 3'd1, 3'd0}),
      .CNT_W(4)
   ) dut8 (
      .clk(clk), .rst_n(rst_n),
      .in_valid(s_in_valid), .in_ready(s_in_ready), .in_data(s_in_data), .in_dec(s_in_dec), .in_iter(s_in_iter),
      .out_valid(s_out_valid), .out_ready(s_out_ready), .out_data(s_out_data), .out_dec(s_out_dec), .busy(s_busy)
   );

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Present one word, wait for the result, return it with the latency in edges
   // counted from the accept edge inclusive, then complete the output handshake.
   task automatic run_op(input logic [63:0] d, input logic dec, input logic [3:0] it,
                         output logic [63:0] res, output logic rdec, output int lat);
      int bound;
      @(negedge clk);
      in_valid = 1'b1; in_data = d; in_dec = dec; in_iter = it;
      bound = 0;
      while (!in_ready && bound < 50) begin @(negedge clk); bound++; end
      @(posedge clk);
      lat = 1;
      #1;
      in_valid = 1'b0; in_data = 64'hDEAD_BEEF_CAFE_F00D; in_dec = ~dec; in_iter = 4'hF;
      @(negedge clk);
      while (!out_valid && lat < 40) begin @(posedge clk); lat++; @(negedge clk); end
      res  = out_data;
      rdec = out_dec;
      out_ready = 1'b1;
      @(posedge clk);
      #1 out_ready = 1'b0;
   endtask

   initial begin
      logic [63:0] res, res2, word, held;
      logic        rdec;
      int          lat;
      logic [3:0]  it;
      int          bound;

      rst_n = 1'b0; in_valid = 1'b0; in_data = '0; in_dec = 1'b0; in_iter = '0; out_ready = 1'b0;
      s_in_valid = 1'b0; s_in_data = '0; s_in_dec = 1'b0; s_in_iter = '0; s_out_ready = 1'b0;
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;

      // Reset state
      @(negedge clk);
      check("rst_out_valid", 64'(out_valid), 64'd0);
      check("rst_in_ready",  64'(in_ready),  64'd1);
      check("rst_busy",      64'(busy),      64'd0);
      check("rst_out_data",  out_data,       64'd0);
      check("rst_out_dec",   64'(out_dec),   64'd0);

      // 1. Encrypt, one iteration
      run_op(64'h0001_0001_0001_0001, 1'b0, 4'd1, res, rdec, lat);
      check("enc1_data", res, 64'h0200_0080_0010_0002);
      check("enc1_dec",  64'(rdec), 64'd0);
      check("enc1_lat",  64'(lat),  64'd2);

      // 2. Decrypt, one iteration
      run_op(64'h0200_0080_0010_0002, 1'b1, 4'd1, res, rdec, lat);
      check("dec1_data", res, 64'h0001_0001_0001_0001);
      check("dec1_dec",  64'(rdec), 64'd1);

      // 3. Two iterations and lane wrap-around
      run_op(64'h0001_0001_0001_0001, 1'b0, 4'd2, res, rdec, lat);
      check("enc2_data", res, 64'h0004_4000_0100_0004);
      check("enc2_lat",  64'(lat), 64'd3);
      run_op(64'h0000_0000_0000_8000, 1'b0, 4'd1, res, rdec, lat);
      check("wrap_data", res, 64'h0000_0000_0000_0001);

      // 15 iterations: lane rotations 15,60,105,135 mod 16 = 15,12,9,7
      run_op(64'h0001_0001_0001_0001, 1'b0, 4'd15, res, rdec, lat);
      check("enc15_data", res, 64'h0080_0200_1000_8000);
      check("enc15_lat",  64'(lat), 64'd16);

      // 4. Pass-through, then back-pressure with ignored input pulses
      run_op(64'h1234_5678_9ABC_DEF0, 1'b1, 4'd0, res, rdec, lat);
      check("pass_data", res, 64'h1234_5678_9ABC_DEF0);
      check("pass_lat",  64'(lat), 64'd1);
      check("pass_dec",  64'(rdec), 64'd1);

      @(negedge clk);
      in_valid = 1'b1; in_data = 64'hA5A5_0F0F_3C3C_FFFF; in_dec = 1'b0; in_iter = 4'd0;
      @(posedge clk);
      #1 in_valid = 1'b0;
      held = 64'hA5A5_0F0F_3C3C_FFFF;
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         in_valid = k[0]; in_data = 64'h1111_2222_3333_4444; in_iter = 4'd3; in_dec = 1'b1;
         check("bp_out_data",  out_data,       held);
         check("bp_out_valid", 64'(out_valid), 64'd1);
         check("bp_in_ready",  64'(in_ready),  64'd0);
         check("bp_out_dec",   64'(out_dec),   64'd0);
      end
      @(negedge clk);
      in_valid = 1'b0;
      out_ready = 1'b1;
      @(posedge clk);
      #1 out_ready = 1'b0;
      @(negedge clk);
      check("bp_release_valid", 64'(out_valid), 64'd0);
      check("bp_release_ready", 64'(in_ready),  64'd1);
      check("bp_release_data",  out_data,       held);

      // 5. Reset in the fourth RUN cycle
      @(negedge clk);
      in_valid = 1'b1; in_data = 64'h0001_0001_0001_0001; in_dec = 1'b0; in_iter = 4'd15;
      @(posedge clk);
      #1 in_valid = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("run_busy",     64'(busy),     64'd1);
      check("run_in_ready", 64'(in_ready), 64'd0);
      rst_n = 1'b0;
      @(posedge clk);
      #1 rst_n = 1'b1;
      @(negedge clk);
      check("mrst_out_valid", 64'(out_valid), 64'd0);
      check("mrst_out_data",  out_data,       64'd0);
      check("mrst_in_ready",  64'(in_ready),  64'd1);
      check("mrst_busy",      64'(busy),      64'd0);
      run_op(64'h0001_0001_0001_0001, 1'b0, 4'd1, res, rdec, lat);
      check("post_rst_data", res, 64'h0200_0080_0010_0002);
      check("post_rst_lat",  64'(lat), 64'd2);

      // Random round-trips: decrypt with the same iteration count restores the word
      for (int n = 0; n < 1000; n++) begin
         word = {$urandom, $urandom};
         it   = 4'($urandom_range(0, 15));
         run_op(word, 1'b0, it, res, rdec, lat);
         run_op(res, 1'b1, it, res2, rdec, lat);
         check("roundtrip", res2, word);
      end

      // 6. Eight 8-bit lanes, lane i rotates by i
      @(negedge clk);
      s_in_valid = 1'b1; s_in_data = 64'h0101_0101_0101_0101; s_in_dec = 1'b0; s_in_iter = 4'd1;
      @(posedge clk);
      #1 s_in_valid = 1'b0;
      bound = 0;
      @(negedge clk);
      while (!s_out_valid && bound < 40) begin @(negedge clk); bound++; end
      check("p8_valid", 64'(s_out_valid), 64'd1);
      check("p8_data",  s_out_data, 64'h8040_2010_0804_0201);
      s_out_ready = 1'b1;
      @(posedge clk);
      #1 s_out_ready = 1'b0;

      @(negedge clk);
      s_in_valid = 1'b1; s_in_data = 64'h8040_2010_0804_0201; s_in_dec = 1'b1; s_in_iter = 4'd1;
      @(posedge clk);
      #1 s_in_valid = 1'b0;
      bound = 0;
      @(negedge clk);
      while (!s_out_valid && bound < 40) begin @(negedge clk); bound++; end
      check("p8_dec_data", s_out_data, 64'h0101_0101_0101_0101);
      s_out_ready = 1'b1;
      @(posedge clk);
      #1 s_out_ready = 1'b0;

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
